sprite_line_fetcher: RTL and testbench

SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

---
 rtl/sprite_line_fetcher.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Walks the active sprite list for one scanline and draws each sprite's
//   tiles into the line buffer. Per tile: tilemap read -> bitmap read ->
//   16 pixel writes (8 source pixels, each doubled horizontally).
// Ports:
//   clk_draw, rst_draw       draw clock, async active-high reset
//   line                     start-of-line pulse (restarts the list walk)
//   sprite_index             active-list index presented to the matcher
//   valid, tilemap_addr,     matcher entry, valid one cycle after index
//   bitmap_addr
//   tm_rd_en/addr/data       tilemap read port (data one cycle after en)
//   bm_rd_en/addr/data       bitmap read port (data one cycle after en)
//   lb_we/waddr/wdata        line-buffer pixel write
//   busy, overrun            list walk in progress / sticky line-while-busy

package sprite_line_fetcher_pkg;
    localparam int unsigned TM_ADDR_W  = 14;
    localparam int unsigned TILE_CNT_W = 5;
    localparam int unsigned LB_ADDR_W  = 12;
    localparam int unsigned BM_ADDR_W  = 18;
    localparam int unsigned IDX_W      = 9;

    typedef struct packed {
        logic                  x_flip;
        logic [TILE_CNT_W-1:0] tile_count;
        logic [TM_ADDR_W-1:0]  tilemap_addr;
    } active_tilemap_addr_t;

    typedef struct packed {
        logic [LB_ADDR_W-1:0] lb_addr;
        logic [BM_ADDR_W-1:0] tile_bitmap_addr;
    } active_bitmap_addr_t;
endpackage

module sprite_line_fetcher
    import sprite_line_fetcher_pkg::*;
#(
    parameter int unsigned LB_SIZE   = 1280,
    parameter int unsigned MAX_TILES = 16
) (
    input  logic                       clk_draw,
    input  logic                       rst_draw,
    input  logic                       line,
    output logic [IDX_W-1:0]           sprite_index,
    input  logic                       valid,
    input  active_tilemap_addr_t       tilemap_addr,
    input  active_bitmap_addr_t        bitmap_addr,
    output logic                       tm_rd_en,
    output logic [TM_ADDR_W-1:0]       tm_rd_addr,
    input  logic [15:0]                tm_rd_data,
    output logic                       bm_rd_en,
    output logic [BM_ADDR_W-1:0]       bm_rd_addr,
    input  logic [31:0]                bm_rd_data,
    output logic                       lb_we,
    output logic [LB_ADDR_W-1:0]       lb_waddr,
    output logic [3:0]                 lb_wdata,
    output logic                       busy,
    output logic                       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_TILEMAP,
        S_BITMAP,
        S_DRAW
    } state_t;

    state_t                 state_q, state_n;
    logic                   phase_q, phase_n;       // first/second cycle of ENTRY, TILEMAP, BITMAP
    logic [3:0]             k_q, k_n;               // draw step within a tile
    logic                   flip_q, flip_n;
    logic [TM_ADDR_W-1:0]   tm_base_q, tm_base_n;
    logic [BM_ADDR_W-1:0]   bm_base_q, bm_base_n;
    logic [LB_ADDR_W-1:0]   x_cur_q, x_cur_n;
    logic [TILE_CNT_W-1:0]  cnt_q, cnt_n;           // tiles still to draw
    logic [TILE_CNT_W-1:0]  tile_num_q, tile_num_n; // tiles already drawn
    logic [31:0]            row_q, row_n;

    logic [IDX_W-1:0]       sprite_index_n;
    logic                   busy_n, overrun_n;
    logic                   tm_rd_en_n, bm_rd_en_n, lb_we_n;
    logic [TM_ADDR_W-1:0]   tm_rd_addr_n;
    logic [BM_ADDR_W-1:0]   bm_rd_addr_n;
    logic [LB_ADDR_W-1:0]   lb_waddr_n;
    logic [3:0]             lb_wdata_n;
    logic                   sprite_done;

    logic [TILE_CNT_W-1:0]  clamp_cnt;
    logic [31:0]            draw_word;
    logic [3:0]             draw_k;
    logic [2:0]             src_idx;
    logic [3:0]             draw_pix;
    logic [LB_ADDR_W-1:0]   draw_addr;
    logic                   draw_we;
    logic                   unused_tm_hi;

    // Only the tile-index field of the tilemap word is consumed.
    assign unused_tm_hi = ^tm_rd_data[15:10];

    assign clamp_cnt = (32'(tilemap_addr.tile_count) > MAX_TILES)
                     ? TILE_CNT_W'(MAX_TILES) : tilemap_addr.tile_count;

    // Pixel for the next write: step 0 comes straight off the bitmap port,
    // later steps from the captured row.
    always_comb begin
        draw_word = row_q;
        draw_k    = k_q + 4'd1;
        if (state_q == S_BITMAP) begin
            draw_word = bm_rd_data;
            draw_k    = 4'd0;
        end
        src_idx   = flip_q ? 3'(3'd7 - draw_k[3:1]) : draw_k[3:1];
        draw_pix  = draw_word[{src_idx, 2'b00} +: 4];
        draw_addr = x_cur_q + LB_ADDR_W'(draw_k);
        draw_we   = (draw_pix != 4'd0) && (32'(draw_addr) < LB_SIZE);
    end

    // State and output registers.
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            k_q          <= '0;
            flip_q       <= 1'b0;
            tm_base_q    <= '0;
            bm_base_q    <= '0;
            x_cur_q      <= '0;
            cnt_q        <= '0;
            tile_num_q   <= '0;
            row_q        <= '0;
            sprite_index <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            tm_rd_en     <= 1'b0;
            tm_rd_addr   <= '0;
            bm_rd_en     <= 1'b0;
            bm_rd_addr   <= '0;
            lb_we        <= 1'b0;
            lb_waddr     <= '0;
            lb_wdata     <= '0;
        end else begin
            state_q      <= state_n;
            phase_q      <= phase_n;
            k_q          <= k_n;
            flip_q       <= flip_n;
            tm_base_q    <= tm_base_n;
            bm_base_q    <= bm_base_n;
            x_cur_q      <= x_cur_n;
            cnt_q        <= cnt_n;
            tile_num_q   <= tile_num_n;
            row_q        <= row_n;
            sprite_index <= sprite_index_n;
            busy         <= busy_n;
            overrun      <= overrun_n;
            tm_rd_en     <= tm_rd_en_n;
            tm_rd_addr   <= tm_rd_addr_n;
            bm_rd_en     <= bm_rd_en_n;
            bm_rd_addr   <= bm_rd_addr_n;
            lb_we        <= lb_we_n;
            lb_waddr     <= lb_waddr_n;
            lb_wdata     <= lb_wdata_n;
        end
    end

    // Next-state and next-output logic. Read strobes and writes are
    // one-cycle pulses, so they default low.
    always_comb begin
        state_n        = state_q;
        phase_n        = phase_q;
        k_n            = k_q;
        flip_n         = flip_q;
        tm_base_n      = tm_base_q;
        bm_base_n      = bm_base_q;
        x_cur_n        = x_cur_q;
        cnt_n          = cnt_q;
        tile_num_n     = tile_num_q;
        row_n          = row_q;
        sprite_index_n = sprite_index;
        busy_n         = busy;
        overrun_n      = overrun;
        tm_rd_en_n     = 1'b0;
        tm_rd_addr_n   = tm_rd_addr;
        bm_rd_en_n     = 1'b0;
        bm_rd_addr_n   = bm_rd_addr;
        lb_we_n        = 1'b0;
        lb_waddr_n     = lb_waddr;
        lb_wdata_n     = lb_wdata;
        sprite_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
            end

            S_ENTRY: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (!valid) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        flip_n     = tilemap_addr.x_flip;
                        tm_base_n  = tilemap_addr.tilemap_addr;
                        bm_base_n  = bitmap_addr.tile_bitmap_addr;
                        x_cur_n    = bitmap_addr.lb_addr;
                        cnt_n      = clamp_cnt;
                        tile_num_n = '0;
                        if (clamp_cnt == '0) begin
                            sprite_done = 1'b1;
                        end else begin
                            state_n      = S_TILEMAP;
                            tm_rd_en_n   = 1'b1;
                            tm_rd_addr_n = tilemap_addr.tilemap_addr;
                        end
                    end
                end
            end

            S_TILEMAP: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n      = 1'b0;
                    state_n      = S_BITMAP;
                    bm_rd_en_n   = 1'b1;
                    bm_rd_addr_n = bm_base_q + BM_ADDR_W'(tm_rd_data[9:0]);
                end
            end

            S_BITMAP: begin
                if (!phase_q) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n    = 1'b0;
                    state_n    = S_DRAW;
                    row_n      = bm_rd_data;
                    k_n        = 4'd0;
                    lb_we_n    = draw_we;
                    lb_waddr_n = draw_addr;
                    lb_wdata_n = draw_pix;
                end
            end

            S_DRAW: begin
                if (k_q != 4'd15) begin
                    k_n        = k_q + 4'd1;
                    lb_we_n    = draw_we;
                    lb_waddr_n = draw_addr;
                    lb_wdata_n = draw_pix;
                end else begin
                    x_cur_n    = x_cur_q + LB_ADDR_W'(16);
                    cnt_n      = cnt_q - TILE_CNT_W'(1);
                    tile_num_n = tile_num_q + TILE_CNT_W'(1);
                    if (cnt_q != TILE_CNT_W'(1)) begin
                        state_n      = S_TILEMAP;
                        tm_rd_en_n   = 1'b1;
                        tm_rd_addr_n = tm_base_q + TM_ADDR_W'(tile_num_q + TILE_CNT_W'(1));
                    end else begin
                        sprite_done = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Index 511 is the last list slot: stop instead of wrapping.
        if (sprite_done) begin
            phase_n = 1'b0;
            if (&sprite_index) begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end else begin
                state_n        = S_ENTRY;
                sprite_index_n = sprite_index + IDX_W'(1);
            end
        end

        // A line pulse restarts the walk from any state, dropping any tile
        // in flight.
        if (line) begin
            overrun_n      = overrun | busy;
            state_n        = S_ENTRY;
            phase_n        = 1'b0;
            sprite_index_n = '0;
            busy_n         = 1'b1;
            tm_rd_en_n     = 1'b0;
            bm_rd_en_n     = 1'b0;
            lb_we_n        = 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher
//   Acts as matcher, tilemap and bitmap memories for sprite_line_fetcher
//   and compares its reads, pixel writes and line timing against a
//   list-level model of the drawing rules.
`timescale 1ns/1ps
module tb_sprite_line_fetcher;
    import sprite_line_fetcher_pkg::*;

    localparam int LB_SZ   = 1280;
    localparam int MAXT    = 16;
    localparam int BOUND   = 30000;

    typedef struct {
        logic v;
        logic fl;
        int   tc;
        int   tma;
        int   lb;
        int   tba;
    } ent_t;

    logic                 clk_draw = 1'b0;
    logic                 rst_draw = 1'b1;
    logic                 line     = 1'b0;
    logic [8:0]           sprite_index;
    logic                 valid    = 1'b0;
    active_tilemap_addr_t tm_ent;
    active_bitmap_addr_t  bm_ent;
    logic                 tm_rd_en;
    logic [13:0]          tm_rd_addr;
    logic [15:0]          tm_rd_data = 16'd0;
    logic                 bm_rd_en;
    logic [17:0]          bm_rd_addr;
    logic [31:0]          bm_rd_data = 32'd0;
    logic                 lb_we;
    logic [11:0]          lb_waddr;
    logic [3:0]           lb_wdata;
    logic                 busy;
    logic                 overrun;

    sprite_line_fetcher dut (
        .clk_draw     (clk_draw),
        .rst_draw     (rst_draw),
        .line         (line),
        .sprite_index (sprite_index),
        .valid        (valid),
        .tilemap_addr (tm_ent),
        .bitmap_addr  (bm_ent),
        .tm_rd_en     (tm_rd_en),
        .tm_rd_addr   (tm_rd_addr),
        .tm_rd_data   (tm_rd_data),
        .bm_rd_en     (bm_rd_en),
        .bm_rd_addr   (bm_rd_addr),
        .bm_rd_data   (bm_rd_data),
        .lb_we        (lb_we),
        .lb_waddr     (lb_waddr),
        .lb_wdata     (lb_wdata),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk_draw = ~clk_draw;

    ent_t        ents [512];
    logic [15:0] tm_mem [int];
    logic [31:0] bm_mem [int];

    int n_cmp = 0;
    int n_bad = 0;

    int ewq[$], awq[$], etmq[$], atmq[$], ebmq[$], abmq[$];
    int busy_cnt = 0;

    logic [8:0]  idx_s    = '0;
    logic        tm_en_s  = 1'b0;
    logic [13:0] tm_addr_s = '0;
    logic        bm_en_s  = 1'b0;
    logic [17:0] bm_addr_s = '0;

    function automatic logic [15:0] tm_word(input int a);
        if (tm_mem.exists(a)) return tm_mem[a];
        return 16'(a * 40503 + 12345);
    endfunction

    function automatic logic [31:0] bm_word(input int a);
        logic [31:0] x;
        if (bm_mem.exists(a)) return bm_mem[a];
        x = 32'(a);
        return (x * 32'h9E3779B1) ^ {x[15:0], x[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe DUT outputs mid-cycle; also latch what the memories see.
    always @(negedge clk_draw) begin
        idx_s     = sprite_index;
        tm_en_s   = tm_rd_en;
        tm_addr_s = tm_rd_addr;
        bm_en_s   = bm_rd_en;
        bm_addr_s = bm_rd_addr;
        if (!rst_draw) begin
            if (lb_we)    awq.push_back(int'(lb_waddr) * 16 + int'(lb_wdata));
            if (tm_rd_en) atmq.push_back(int'(tm_rd_addr));
            if (bm_rd_en) abmq.push_back(int'(bm_rd_addr));
            if (busy)     busy_cnt++;
        end
    end

    // Registered matcher lookup and one-cycle-latency memories.
    always begin
        @(posedge clk_draw);
        #1;
        valid                   = ents[idx_s].v;
        tm_ent.x_flip           = ents[idx_s].fl;
        tm_ent.tile_count       = 5'(ents[idx_s].tc);
        tm_ent.tilemap_addr     = 14'(ents[idx_s].tma);
        bm_ent.lb_addr          = 12'(ents[idx_s].lb);
        bm_ent.tile_bitmap_addr = 18'(ents[idx_s].tba);
        tm_rd_data = tm_en_s ? tm_word(int'(tm_addr_s)) : 16'($urandom);
        bm_rd_data = bm_en_s ? bm_word(int'(bm_addr_s)) : 32'($urandom);
    end

    // List-level model of one line: reads, writes and busy length.
    task automatic build_expect(output int exp_busy);
        int n, tmaddr, ti, bmaddr, src, px, ad;
        logic [31:0] w;
        ewq.delete(); etmq.delete(); ebmq.delete();
        exp_busy = 0;
        for (int i = 0; i < 512; i++) begin
            exp_busy += 2;
            if (!ents[i].v) break;
            n = (ents[i].tc > MAXT) ? MAXT : ents[i].tc;
            for (int t = 0; t < n; t++) begin
                tmaddr = (ents[i].tma + t) % 16384;
                ti     = int'(tm_word(tmaddr)) & 32'h3FF;
                bmaddr = (ents[i].tba + ti) % 262144;
                w      = bm_word(bmaddr);
                etmq.push_back(tmaddr);
                ebmq.push_back(bmaddr);
                for (int k = 0; k < 16; k++) begin
                    src = ents[i].fl ? 7 - k / 2 : k / 2;
                    px  = int'((w >> (4 * src)) & 32'hF);
                    ad  = (ents[i].lb + 16 * t + k) % 4096;
                    if (px != 0 && ad < LB_SZ) ewq.push_back(ad * 16 + px);
                end
                exp_busy += 20;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 512; i++) ents[i] = '{v:1'b0, fl:1'b0, tc:0, tma:0, lb:0, tba:0};
        tm_mem.delete();
        bm_mem.delete();
    endtask

    task automatic clear_mon();
        awq.delete(); atmq.delete(); abmq.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse_line();
        @(posedge clk_draw); #1 line = 1'b1;
        @(posedge clk_draw); #1 line = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < BOUND) begin
            @(negedge clk_draw);
            guard++;
        end
        chk({tag, "_finished"}, 64'(guard < BOUND), 64'd1);
        repeat (2) @(negedge clk_draw);
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, "_n_tm"}, 64'(atmq.size()), 64'(etmq.size()));
        for (int i = 0; i < atmq.size() && i < etmq.size(); i++) begin
            chk({tag, "_tm_addr"}, 64'(atmq[i]), 64'(etmq[i]));
            if (atmq[i] != etmq[i]) break;
        end
        chk({tag, "_n_bm"}, 64'(abmq.size()), 64'(ebmq.size()));
        for (int i = 0; i < abmq.size() && i < ebmq.size(); i++) begin
            chk({tag, "_bm_addr"}, 64'(abmq[i]), 64'(ebmq[i]));
            if (abmq[i] != ebmq[i]) break;
        end
        chk({tag, "_n_writes"}, 64'(awq.size()), 64'(ewq.size()));
        for (int i = 0; i < awq.size() && i < ewq.size(); i++) begin
            chk({tag, "_write_addr_data"}, 64'(awq[i]), 64'(ewq[i]));
            if (awq[i] != ewq[i]) break;
        end
    endtask

    task automatic run_line(input string tag, input logic exp_ovr);
        int eb;
        build_expect(eb);
        clear_mon();
        pulse_line();
        wait_idle(tag);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(eb));
        chk({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
        compare_queues(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sprite_index"}, 64'(sprite_index), 64'd0);
        chk({tag, "_busy"},         64'(busy),         64'd0);
        chk({tag, "_overrun"},      64'(overrun),      64'd0);
        chk({tag, "_tm_rd_en"},     64'(tm_rd_en),     64'd0);
        chk({tag, "_bm_rd_en"},     64'(bm_rd_en),     64'd0);
        chk({tag, "_lb_we"},        64'(lb_we),        64'd0);
        chk({tag, "_lb_waddr"},     64'(lb_waddr),     64'd0);
        chk({tag, "_lb_wdata"},     64'(lb_wdata),     64'd0);
        chk({tag, "_tm_rd_addr"},   64'(tm_rd_addr),   64'd0);
        chk({tag, "_bm_rd_addr"},   64'(bm_rd_addr),   64'd0);
    endtask

    task automatic setup_basic(input logic fl, input int tc, input logic [31:0] word);
        clear_all();
        ents[0] = '{v:1'b1, fl:fl, tc:tc, tma:7, lb:100, tba:'h200};
        for (int t = 0; t < 16; t++) tm_mem[7 + t] = 16'd5;
        bm_mem['h205] = word;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, lbv, nsp;
        tm_ent = '0;
        bm_ent = '0;
        clear_all();
        clear_mon();

        // Reset state and idle after release.
        repeat (3) @(negedge clk_draw);
        check_reset_vals("reset");
        rst_draw = 1'b0;
        repeat (6) @(negedge clk_draw);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_no_reads", 64'(atmq.size() + abmq.size() + awq.size()), 64'd0);

        // Single tile, normal orientation.
        setup_basic(1'b0, 1, 32'h87654321);
        run_line("basic", 1'b0);
        chk("basic_bm_addr", 64'(abmq.size() > 0 ? abmq[0] : -1), 64'h205);
        chk("basic_n_writes16", 64'(awq.size()), 64'd16);
        if (awq.size() == 16) begin
            for (int j = 0; j < 16; j++)
                chk("basic_pixel", 64'(awq[j]), 64'((100 + j) * 16 + j / 2 + 1));
        end
        chk("basic_sprite_index_end", 64'(sprite_index), 64'd1);

        // Single tile, mirrored.
        setup_basic(1'b1, 1, 32'h87654321);
        run_line("flip", 1'b0);
        if (awq.size() == 16) begin
            for (int j = 0; j < 16; j++)
                chk("flip_pixel", 64'(awq[j]), 64'((100 + j) * 16 + 8 - j / 2));
        end

        // Transparent pixels produce no writes.
        setup_basic(1'b0, 1, 32'h00000F00);
        run_line("sparse", 1'b0);
        chk("sparse_n_writes", 64'(awq.size()), 64'd2);
        if (awq.size() == 2) begin
            chk("sparse_w0", 64'(awq[0]), 64'(104 * 16 + 15));
            chk("sparse_w1", 64'(awq[1]), 64'(105 * 16 + 15));
        end

        // Three tiles running off the visible edge.
        clear_all();
        ents[0] = '{v:1'b1, fl:1'b0, tc:3, tma:40, lb:1260, tba:'h200};
        for (int t = 40; t < 43; t++) tm_mem[t] = 16'd5;
        bm_mem['h205] = 32'h87654321;
        run_line("edge", 1'b0);
        chk("edge_busy64", 64'(busy_cnt), 64'd64);
        if (atmq.size() == 3) begin
            for (int t = 0; t < 3; t++) chk("edge_tm_addr", 64'(atmq[t]), 64'(40 + t));
        end
        chk("edge_n_writes", 64'(awq.size()), 64'd20);
        if (awq.size() == 20) chk("edge_last_addr", 64'(awq[19] / 16), 64'd1279);

        // tile_count above the cap.
        clear_all();
        ents[0] = '{v:1'b1, fl:1'b0, tc:21, tma:100, lb:0, tba:'h1000};
        run_line("clamp", 1'b0);
        chk("clamp_n_tiles", 64'(atmq.size()), 64'(MAXT));

        // Full list: index 511 is drawn, then the walk stops.
        clear_all();
        for (int i = 0; i < 511; i++) ents[i] = '{v:1'b1, fl:1'b0, tc:0, tma:0, lb:0, tba:0};
        ents[511] = '{v:1'b1, fl:1'b1, tc:1, tma:50, lb:200, tba:'h300};
        run_line("sat511", 1'b0);
        chk("sat511_index", 64'(sprite_index), 64'd511);

        // Randomized lists.
        for (int r = 0; r < 8; r++) begin
            clear_all();
            nsp = $urandom_range(0, 4);
            for (int i = 0; i < nsp; i++) begin
                case ($urandom_range(0, 3))
                    0:       lbv = $urandom_range(1240, 1290);
                    1:       lbv = $urandom_range(4070, 4095);
                    default: lbv = $urandom_range(0, 4095);
                endcase
                ents[i] = '{v:1'b1, fl:1'($urandom_range(0, 1)), tc:$urandom_range(0, 20),
                            tma:$urandom_range(0, 16383), lb:lbv,
                            tba:($urandom_range(0, 1) != 0) ? $urandom_range(262000, 262143)
                                                            : $urandom_range(0, 262143)};
            end
            run_line("random", 1'b0);
        end

        // Line pulse while busy.
        clear_all();
        ents[0] = '{v:1'b1, fl:1'b0, tc:3, tma:7, lb:100, tba:'h200};
        for (int t = 7; t < 10; t++) tm_mem[t] = 16'd5;
        bm_mem['h205] = 32'h87654321;
        clear_mon();
        pulse_line();
        repeat (30) @(posedge clk_draw);
        #1;
        chk("ovr_before", 64'(overrun), 64'd0);
        chk("ovr_busy_before", 64'(busy), 64'd1);
        line = 1'b1;
        @(posedge clk_draw); #1 line = 1'b0;
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_index", 64'(sprite_index), 64'd0);
        chk("ovr_busy", 64'(busy), 64'd1);
        chk("ovr_lb_we", 64'(lb_we), 64'd0);
        chk("ovr_tm_en", 64'(tm_rd_en), 64'd0);
        wait_idle("ovr_restart");
        run_line("ovr_sticky", 1'b1);

        // Asynchronous reset in the middle of drawing.
        clear_mon();
        pulse_line();
        guard = 0;
        while (lb_we !== 1'b1 && guard < 200) begin
            @(negedge clk_draw);
            guard++;
        end
        chk("mid_draw_reached", 64'(guard < 200), 64'd1);
        rst_draw = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk_draw);
        rst_draw = 1'b0;
        clear_mon();
        repeat (8) @(negedge clk_draw);
        chk("after_reset_idle", 64'(busy), 64'd0);
        chk("after_reset_no_activity", 64'(atmq.size() + abmq.size() + awq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
